// File: rtl/chi_pkg.sv
// CHI response-channel types shared by the link-layer blocks.
// Flit layout, opcodes and link-state encoding.
package chi_pkg;

  typedef enum logic [1:0] {
    STOP,
    ACTIVATE,
    RUN,
    DEACTIVATE
  } lnk_state_e;

  typedef struct packed {
    logic [7:0] dbid;
    logic [2:0] resp;
    logic [1:0] resperr;
    logic [4:0] opcode;
    logic [7:0] txnid;
    logic [6:0] srcid;
    logic [6:0] tgtid;
    logic [3:0] qos;
  } rspflit_t;

  localparam logic [4:0] RSP_LCRDRETURN = 5'h00;
  localparam logic [4:0] RSP_COMP       = 5'h04;

  function automatic rspflit_t lcrd_return_flit();
    rspflit_t f;
    f = '0;
    f.opcode = RSP_LCRDRETURN;
    return f;
  endfunction

endpackage

// File: rtl/lnk_fifo.sv
// Synchronous flit FIFO with wrap-bit pointers, flush and occupancy.
// Push when full and pop when empty are ignored.
module lnk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    widx;
  logic [AW-1:0]    ridx;
  logic             wwrap;
  logic             rwrap;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (widx == ridx) && (wwrap == rwrap);
  assign full    = (widx == ridx) && (wwrap != rwrap);
  assign rdata   = mem[ridx];

  always_comb begin
    if (wwrap == rwrap)
      level = LW'(widx) - LW'(ridx);
    else
      level = LW'(DEPTH) - LW'(ridx) + LW'(widx);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      widx  <= '0;
      wwrap <= 1'b0;
      ridx  <= '0;
      rwrap <= 1'b0;
    end else if (flush) begin
      widx  <= '0;
      wwrap <= 1'b0;
      ridx  <= '0;
      rwrap <= 1'b0;
    end else begin
      if (do_push) begin
        if (widx == AW'(DEPTH - 1)) begin
          widx  <= '0;
          wwrap <= ~wwrap;
        end else begin
          widx <= widx + 1'b1;
        end
      end
      if (do_pop) begin
        if (ridx == AW'(DEPTH - 1)) begin
          ridx  <= '0;
          rwrap <= ~rwrap;
        end else begin
          ridx <= ridx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push)
      mem[widx] <= wdata;
  end

endmodule

// File: rtl/txrsp_lnk_tx.sv
// TXRSP link-layer transmitter: flit buffer, link FSM and L-credits.
// Spare credits go back as LCrdReturn flits while deactivating.
module txrsp_lnk_tx
  import chi_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_LCRD = 15,
  parameter int LCRD_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              link_en,
  input  logic              pin_valid,
  output logic              pin_ready,
  input  rspflit_t          pin_data,
  output logic              txrsp_linkactivereq,
  input  logic              txrsp_linkactiveack,
  output logic              txrsp_flitpend,
  output logic              txrsp_flitv,
  output rspflit_t          txrsp_flit,
  input  logic              txrsp_lcrdv,
  output logic              link_run,
  output logic [LCRD_W-1:0] lcrd_cnt
);

  localparam int LW = $clog2(DEPTH + 1);

  lnk_state_e        state;
  lnk_state_e        state_nxt;
  rspflit_t          head;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic [LW-1:0]     level_nxt;
  logic              push;
  logic              pop;
  logic              ret;
  logic              inc;
  logic              dec;
  logic              lcrd_overflow;
  logic [LCRD_W-1:0] cnt_nxt;

  lnk_fifo #(
    .WIDTH($bits(rspflit_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .wdata(pin_data),
    .rdata(head),
    .full (full),
    .empty(empty),
    .level(level)
  );

  assign pin_ready = (state == RUN) && !full && !flush;
  assign push      = pin_valid && pin_ready;
  assign pop       = (state == RUN) && !empty && (lcrd_cnt != '0);
  assign ret       = (state == DEACTIVATE) && (lcrd_cnt != '0);
  assign dec       = pop || ret;
  assign inc       = txrsp_lcrdv && (state != STOP);

  assign lcrd_overflow =
    inc && !dec && (lcrd_cnt == LCRD_W'(MAX_LCRD));

  always_comb begin
    cnt_nxt = lcrd_cnt;
    unique case (1'b1)
      inc && !dec: if (!lcrd_overflow) cnt_nxt = lcrd_cnt + 1'b1;
      dec && !inc: cnt_nxt = lcrd_cnt - 1'b1;
      default: ;
    endcase
  end

  // A flush also drops the entry popped this cycle; that flit is in flight.
  always_comb begin
    if (flush)
      level_nxt = '0;
    else
      level_nxt = level + LW'(push) - LW'(pop);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      STOP:
        if (link_en && !txrsp_linkactiveack) state_nxt = ACTIVATE;
      ACTIVATE:
        if (txrsp_linkactiveack) state_nxt = RUN;
      RUN:
        if (!link_en && empty && !push && !pop) state_nxt = DEACTIVATE;
      DEACTIVATE:
        if (!txrsp_linkactiveack && lcrd_cnt == '0) state_nxt = STOP;
      default:
        state_nxt = STOP;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= STOP;
      lcrd_cnt            <= '0;
      txrsp_linkactivereq <= 1'b0;
      link_run            <= 1'b0;
      txrsp_flitpend      <= 1'b0;
      txrsp_flitv         <= 1'b0;
      txrsp_flit          <= '0;
    end else begin
      state               <= state_nxt;
      lcrd_cnt            <= cnt_nxt;
      txrsp_linkactivereq <= (state_nxt == ACTIVATE) || (state_nxt == RUN);
      link_run            <= (state_nxt == RUN);
      txrsp_flitpend      <= (level_nxt != '0) ||
                             ((state_nxt == DEACTIVATE) && (cnt_nxt != '0));
      txrsp_flitv         <= dec;
      if (pop)
        txrsp_flit <= head;
      else if (ret)
        txrsp_flit <= lcrd_return_flit();
      else
        txrsp_flit <= '0;
    end
  end

endmodule

// File: tb/tb_txrsp_lnk_tx.sv
// Directed bench for txrsp_lnk_tx: bring-up, credits, wrap, deactivate,
// flush and asynchronous reset.
module tb_txrsp_lnk_tx;
  import chi_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       link_en = 1'b0;
  logic       pin_valid = 1'b0;
  rspflit_t   pin_data = '0;
  logic       pin_ready;
  logic       req;
  logic       ack = 1'b0;
  logic       pend;
  logic       flitv;
  rspflit_t   flit;
  logic       lcrdv = 1'b0;
  logic       link_run;
  logic [3:0] lcrd_cnt;

  int checks = 0;
  int failures = 0;
  rspflit_t mon_q[$];
  logic prev_pend = 1'b0;

  txrsp_lnk_tx #(.DEPTH(2), .MAX_LCRD(15), .LCRD_W(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .link_en            (link_en),
    .pin_valid          (pin_valid),
    .pin_ready          (pin_ready),
    .pin_data           (pin_data),
    .txrsp_linkactivereq(req),
    .txrsp_linkactiveack(ack),
    .txrsp_flitpend     (pend),
    .txrsp_flitv        (flitv),
    .txrsp_flit         (flit),
    .txrsp_lcrdv        (lcrdv),
    .link_run           (link_run),
    .lcrd_cnt           (lcrd_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (flitv) begin
      chk("pend_before_flitv", 64'(prev_pend), 64'd1);
      mon_q.push_back(flit);
    end
    prev_pend = pend;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic rspflit_t mkflit(input logic [7:0] id);
    rspflit_t f;
    f = '0;
    f.opcode = RSP_COMP;
    f.txnid = id;
    f.srcid = 7'h11;
    f.tgtid = 7'h22;
    return f;
  endfunction

  task automatic push(input logic [7:0] id);
    int budget = 40;
    pin_valid = 1'b1;
    pin_data = mkflit(id);
    #1;
    while (!pin_ready && budget > 0) begin
      tick();
      #1;
      budget--;
    end
    chk("push_ready", 64'(pin_ready), 64'd1);
    tick();
    pin_valid = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input int first, input int n);
    chk({tag, "_count"}, 64'(mon_q.size()), 64'(n));
    for (int i = 0; i < n; i++)
      chk(tag, (i < mon_q.size()) ? 64'(mon_q[i].txnid) : 64'hff,
          64'(first + i));
    mon_q.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, 64'({req, link_run, flitv, pend, pin_ready}), 64'd0);
    chk({tag, "_flit"}, 64'(flit), 64'd0);
    chk({tag, "_cnt"}, 64'(lcrd_cnt), 64'd0);
  endtask

  initial begin
    repeat (2) tick();
    chk_idle("reset");
    reset = 1'b1;
    tick();

    // bring-up
    link_en = 1'b1;
    tick();
    chk("req_rise", 64'(req), 64'd1);
    chk("run_early", 64'(link_run), 64'd0);
    repeat (3) tick();
    ack = 1'b1;
    chk("run_before_ack", 64'(link_run), 64'd0);
    tick();
    chk("run_up", 64'(link_run), 64'd1);
    chk("cnt_up", 64'(lcrd_cnt), 64'd0);
    chk("ready_up", 64'(pin_ready), 64'd1);

    // credit gating
    lcrdv = 1'b1;
    repeat (3) tick();
    lcrdv = 1'b0;
    chk("cnt_3", 64'(lcrd_cnt), 64'd3);
    for (int i = 1; i <= 5; i++) push(8'(i));
    repeat (3) tick();
    chk_seq("gate_first", 1, 3);
    chk("gate_cnt0", 64'(lcrd_cnt), 64'd0);
    chk("gate_pend", 64'(pend), 64'd1);
    chk("gate_full", 64'(pin_ready), 64'd0);
    lcrdv = 1'b1;
    repeat (2) tick();
    lcrdv = 1'b0;
    repeat (3) tick();
    chk_seq("gate_rest", 4, 2);
    chk("gate_pend_drop", 64'(pend), 64'd0);
    chk("gate_cnt_end", 64'(lcrd_cnt), 64'd0);

    // simultaneous grant and issue
    lcrdv = 1'b1;
    tick();
    lcrdv = 1'b0;
    push(8'd6);
    lcrdv = 1'b1;
    tick();
    lcrdv = 1'b0;
    chk("simul_cnt", 64'(lcrd_cnt), 64'd1);
    chk("simul_flitv", 64'(flitv), 64'd1);
    chk("simul_txnid", 64'(flit.txnid), 64'd6);
    push(8'd7);
    repeat (2) tick();
    chk("simul_cnt0", 64'(lcrd_cnt), 64'd0);
    chk_seq("simul_seq", 6, 2);

    // full and wrap-around
    push(8'd10);
    push(8'd11);
    pin_valid = 1'b1;
    pin_data = mkflit(8'd12);
    #1;
    chk("full_ready", 64'(pin_ready), 64'd0);
    tick();
    chk("full_hold", 64'(pin_ready), 64'd0);
    fork
      begin
        lcrdv = 1'b1;
        repeat (8) tick();
        lcrdv = 1'b0;
      end
      begin
        for (int i = 12; i <= 17; i++) push(8'(i));
      end
    join
    repeat (6) tick();
    chk_seq("wrap", 10, 8);
    chk("wrap_cnt", 64'(lcrd_cnt), 64'd0);

    // saturation
    lcrdv = 1'b1;
    repeat (15) tick();
    #1;
    chk("sat_15", 64'(lcrd_cnt), 64'd15);
    chk("sat_ovf", 64'(dut.lcrd_overflow), 64'd1);
    tick();
    lcrdv = 1'b0;
    chk("sat_hold", 64'(lcrd_cnt), 64'd15);
    for (int i = 20; i <= 30; i++) push(8'(i));
    repeat (4) tick();
    chk("sat_spent", 64'(lcrd_cnt), 64'd4);
    chk_seq("sat_seq", 20, 11);

    // deactivate with credit return
    link_en = 1'b0;
    tick();
    chk("deact_req", 64'(req), 64'd0);
    chk("deact_run", 64'(link_run), 64'd0);
    chk("deact_pend", 64'(pend), 64'd1);
    repeat (4) tick();
    chk("deact_cnt", 64'(lcrd_cnt), 64'd0);
    repeat (2) tick();
    chk("ret_count", 64'(mon_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("ret_opcode",
          (i < mon_q.size()) ? 64'(mon_q[i].opcode) : 64'hff,
          64'(RSP_LCRDRETURN));
      chk("ret_flit", (i < mon_q.size()) ? 64'(mon_q[i]) : 64'hff, 64'd0);
    end
    mon_q.delete();
    ack = 1'b0;
    tick();
    chk_idle("stop");

    // flush
    link_en = 1'b1;
    tick();
    ack = 1'b1;
    tick();
    chk("rerun", 64'(link_run), 64'd1);
    push(8'd40);
    push(8'd41);
    chk("flush_pre_pend", 64'(pend), 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(pin_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_pend", 64'(pend), 64'd0);
    chk("flush_ready_back", 64'(pin_ready), 64'd1);
    lcrdv = 1'b1;
    repeat (2) tick();
    lcrdv = 1'b0;
    repeat (3) tick();
    chk("flush_no_flit", 64'(mon_q.size()), 64'd0);
    chk("flush_cnt", 64'(lcrd_cnt), 64'd2);

    // async reset mid-burst
    push(8'd42);
    push(8'd43);
    chk("burst_flitv", 64'(flitv), 64'd1);
    chk("burst_txnid", 64'(flit.txnid), 64'd42);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("async_reset");
    tick();
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
